// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, canonical special
// encodings and the state type of the iterative square-root unit.
package fpu_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_BIAS  = 127;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_PINF = 32'h7F80_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fsqrt_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 operand classifier, shared by the FPU operations.
module fp_classify
   import fpu_pkg::*;
(
   input  logic [31:0] op_i,
   output logic        is_zero_o,
   output logic        is_denorm_o,
   output logic        is_inf_o,
   output logic        is_nan_o,
   output logic        sign_o
);

   logic [FP_EXP_W-1:0] exp_s;
   logic [FP_MAN_W-1:0] man_s;
   logic                exp_zero_s;
   logic                exp_ones_s;
   logic                man_zero_s;

   assign exp_s      = op_i[FP_EXP_W+FP_MAN_W-1:FP_MAN_W];
   assign man_s      = op_i[FP_MAN_W-1:0];
   assign exp_zero_s = (exp_s == {FP_EXP_W{1'b0}});
   assign exp_ones_s = &exp_s;
   assign man_zero_s = (man_s == {FP_MAN_W{1'b0}});

   assign is_zero_o   = exp_zero_s &  man_zero_s;
   assign is_denorm_o = exp_zero_s & ~man_zero_s;
   assign is_inf_o    = exp_ones_s &  man_zero_s;
   assign is_nan_o    = exp_ones_s & ~man_zero_s;
   assign sign_o      = op_i[31];

endmodule

// File: rtl/fsqrt_iter.sv
// Iterative binary32 square root: restoring radix-2 recurrence producing one
// root bit per cycle, round-to-nearest on the final step, valid/ready on both sides.
module fsqrt_iter
   import fpu_pkg::*;
#(
   parameter int ITER = 25
)
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y
);

   localparam int RAD_W = 2 * ITER;
   localparam int REM_W = ITER + 1;
   localparam int CNT_W = $clog2(ITER);

   fsqrt_state_t         state_q, state_d;
   logic [RAD_W-1:0]     rad_q, rad_d;
   logic [REM_W-1:0]     rem_q, rem_d;
   logic [ITER-1:0]      root_q, root_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [FP_EXP_W-1:0]  exp_q, exp_d;
   logic [31:0]          y_q, y_d;

   logic                 is_zero_s, is_denorm_s, is_inf_s, is_nan_s, sign_s;
   logic signed [9:0]    e_unb_s;
   logic signed [9:0]    e_half_s;
   logic signed [9:0]    res_exp_s;
   logic [REM_W+1:0]     rem_sh_s;
   logic [REM_W+1:0]     trial_s;
   logic [REM_W+2:0]     diff_s;
   logic                 bit_s;
   logic [ITER-1:0]      root_next_s;
   logic [ITER-1:0]      mant_rnd_s;
   logic                 carry_s;
   logic [FP_EXP_W-1:0]  exp_rnd_s;
   logic [FP_MAN_W-1:0]  frac_rnd_s;

   fp_classify u_classify (
      .op_i        (x),
      .is_zero_o   (is_zero_s),
      .is_denorm_o (is_denorm_s),
      .is_inf_o    (is_inf_s),
      .is_nan_o    (is_nan_s),
      .sign_o      (sign_s)
   );

   // Halving the unbiased exponent must floor, so an arithmetic shift is used
   assign e_unb_s   = $signed({2'b00, x[30:23]}) - 10'sd127;
   assign e_half_s  = e_unb_s >>> 1;
   assign res_exp_s = e_half_s + 10'sd127;

   assign rem_sh_s    = {rem_q, rad_q[RAD_W-1 -: 2]};
   assign trial_s     = {1'b0, root_q, 2'b01};
   assign diff_s      = {1'b0, rem_sh_s} - {1'b0, trial_s};
   assign bit_s       = ~diff_s[REM_W+2];
   assign root_next_s = {root_q[ITER-2:0], bit_s};

   // Round half-up on the extra root bit; a carry-out renormalises to 2.0
   assign mant_rnd_s = {1'b0, root_next_s[ITER-1:1]} + {{(ITER-1){1'b0}}, root_next_s[0]};
   assign carry_s    = mant_rnd_s[ITER-1];
   assign exp_rnd_s  = exp_q + {{(FP_EXP_W-1){1'b0}}, carry_s};
   assign frac_rnd_s = carry_s ? {FP_MAN_W{1'b0}} : FP_MAN_W'(mant_rnd_s);

   // Next-state logic for the FSM and the recurrence datapath
   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      rem_d   = rem_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = DONE;
               if (is_zero_s || is_denorm_s) begin
                  y_d = {sign_s, 31'b0};
               end else if (is_nan_s || sign_s) begin
                  y_d = FP_QNAN;
               end else if (is_inf_s) begin
                  y_d = FP_PINF;
               end else begin
                  state_d = CALC;
                  rad_d   = e_unb_s[0] ? {1'b1, x[22:0], {(RAD_W-24){1'b0}}}
                                       : {2'b01, x[22:0], {(RAD_W-25){1'b0}}};
                  rem_d   = {REM_W{1'b0}};
                  root_d  = {ITER{1'b0}};
                  cnt_d   = CNT_W'(ITER - 1);
                  exp_d   = FP_EXP_W'(res_exp_s);
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            rem_d  = bit_s ? REM_W'(diff_s) : REM_W'(rem_sh_s);
            root_d = root_next_s;
            rad_d  = rad_q << 2;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = DONE;
               y_d     = {1'b0, exp_rnd_s, frac_rnd_s};
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any operation in flight
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         rad_q   <= {RAD_W{1'b0}};
         rem_q   <= {REM_W{1'b0}};
         root_q  <= {ITER{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         exp_q   <= {FP_EXP_W{1'b0}};
         y_q     <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         y_q     <= y_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// Self-checking bench for fsqrt_iter: vector table, backpressure, mid-op reset
// and random normal operands against an integer-sqrt reference model.
module tb_fsqrt_iter;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;

   int n_chk;
   int n_fail;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] xv;
      logic [31:0] yv;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   fsqrt_iter dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic longint isqrt(input longint r);
      longint lo, hi, mid;
      lo = 0;
      hi = longint'(1) << 25;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= r) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   // Reference for positive normal operands: floor sqrt of the scaled radicand, then round
   function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
      int     e_unb, odd, e_res;
      longint rad, root, mant;
      logic [7:0]  eb;
      logic [22:0] fb;
      e_unb = int'(a[30:23]) - 127;
      odd   = (e_unb % 2 != 0) ? 1 : 0;
      rad   = (longint'(1) << 23) | longint'(a[22:0]);
      rad   = (odd == 1) ? (rad << 26) : (rad << 25);
      root  = isqrt(rad);
      mant  = (root >> 1) + (root & 1);
      e_res = (e_unb - odd) / 2 + 127;
      if (mant >= (longint'(1) << 24)) begin
         mant  = mant >> 1;
         e_res = e_res + 1;
      end
      eb = 8'(e_res);
      fb = 23'(mant);
      return {1'b0, eb, fb};
   endfunction

   task automatic do_op(input logic [31:0] xv, input logic [31:0] yv, input int exp_lat);
      int guard;
      int lat;
      exp_q.push_back(yv);
      in_valid = 1'b1;
      x        = xv;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("accept_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      x        = $urandom;
      lat      = 1;
      while (!out_valid && lat < 60) begin
         tick();
         lat++;
      end
      check("latency", lat, exp_lat);
      check("out_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      check("y", y, exp_q.pop_front());
      tick();
      out_ready = 1'b0;
      check("idle_after", {30'b0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      int guard;
      logic stale;
      logic [31:0] xv;
      logic [31:0] yexp;

      vecs[0]  = '{32'h4080_0000, 32'h4000_0000, 26};
      vecs[1]  = '{32'h4110_0000, 32'h4040_0000, 26};
      vecs[2]  = '{32'h4000_0000, 32'h3FB5_04F3, 26};
      vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 26};
      vecs[4]  = '{32'h3E80_0000, 32'h3F00_0000, 26};
      vecs[5]  = '{32'hBF80_0000, 32'h7FC0_0000, 1};
      vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1};
      vecs[7]  = '{32'h7F80_0000, 32'h7F80_0000, 1};
      vecs[8]  = '{32'h7FC0_0001, 32'h7FC0_0000, 1};
      vecs[9]  = '{32'h0000_0001, 32'h0000_0000, 1};
      vecs[10] = '{32'hFF80_0000, 32'h7FC0_0000, 1};

      n_chk     = 0;
      n_fail    = 0;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_y", y, 32'h0);
      rstn = 1'b1;
      tick();
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].xv, vecs[i].yv, vecs[i].lat);
      end

      // Backpressure: result held for 5 cycles while a new operand waits
      yexp = 32'h4040_0000;
      exp_q.push_back(yexp);
      in_valid = 1'b1;
      x        = 32'h4110_0000;
      tick();
      in_valid = 1'b0;
      guard    = 0;
      while (!out_valid && guard < 60) begin
         tick();
         guard++;
      end
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b1;
      x        = 32'h4080_0000;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_hold", {out_valid, in_ready, 30'b0}, {1'b1, 1'b0, 30'b0});
         check("bp_y", y, yexp);
      end
      out_ready = 1'b1;
      check("bp_y_final", y, exp_q.pop_front());
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp_not_accepted", {30'b0, out_valid, in_ready}, 32'd1);

      // Reset at CALC step 10 must discard the operation
      in_valid = 1'b1;
      x        = 32'h4080_0000;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      #2;
      rstn = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_y", y, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      check("post_rst_ready", {31'b0, in_ready}, 32'd1);
      stale = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (out_valid) stale = 1'b1;
         tick();
      end
      check("post_rst_stale", {31'b0, stale}, 32'd0);
      do_op(32'h4080_0000, 32'h4000_0000, 26);

      for (int i = 0; i < 20; i++) begin
         xv = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
         do_op(xv, ref_sqrt(xv), 26);
      end

      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fsqrt_iter.md
# fsqrt_iter

Iterative single-precision square root unit, the forward counterpart to the FPU's combinational inverse-square-root path. It computes a correctly rounded sqrt(x) with a restoring digit recurrence, one result bit per cycle. It uses valid/ready handshakes on both sides. It sits beside the other FPU ops behind the execute-stage dispatch, and the dispatcher stalls while `in_ready` is low.

## Interface
Parameters:
- `ITER`, 25: recurrence steps (24 mantissa bits plus 1 round bit); fixed for binary32 and not intended to be overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  unit idle and able to accept an operand.
- `x`  in  32  binary32 operand, sampled on the accept edge.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `y`  out  32  binary32 result; stable while `out_valid` is high.

## Operation
- States: IDLE, CALC, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- Accept: `in_valid && in_ready` at edge T. Classify `x` at that edge.

Special cases (IDLE -> DONE directly):
- exponent 0 (zero or denormal, flushed): `y` = {s, 31'b0}.
- NaN, or s=1 with a nonzero exponent: `y` = 32'h7FC00000.
- +inf: `y` = 32'h7F800000.

Normal case (IDLE -> CALC):
- E = e-127.
- Radicand R = {1,m} when E is even, or {1,m}<<1 when E is odd. R is left-aligned into a 50-bit field so its value is in [1,4).
- Result exponent = floor(E/2)+127, computed as an arithmetic shift.
- Clear the remainder and root; load the step counter with ITER-1.

CALC (one step per cycle):
- Bring down the next 2 radicand bits into the remainder.
- Trial subtract = {root,2'b01}.
- If non-negative: keep the difference and shift a 1 into root. Otherwise restore and shift a 0.
- Counter decrements. Go to DONE on the step where the counter is 0.

Rounding on the CALC -> DONE edge:
- root[24:1] = 1.f (24 bits); root[0] = round bit.
- Round half-up on root[0]. Exact ties cannot occur.
- Mantissa carry-out increments the exponent and clears the fraction. This is unreachable for binary32 but must be implemented.

DONE:
- Hold `y` until `out_ready`, then return to IDLE.
- No new accept in the same cycle as the DONE handshake (`in_ready` is low in DONE).

Reset:
- While `rstn` is low: state = IDLE, `out_valid` = 0, `y` = 0, `in_ready` = 1 after release.
- Reset mid-CALC or mid-DONE discards the operation without emitting a result.

## Timing
- Normal operand accepted at edge T: `out_valid` rises after edge T+25, i.e. 25 CALC cycles. Latency is 26 cycles to the first cycle of `out_valid`.
- Special operand: `out_valid` rises after edge T+1.
- Throughput is one op per latency plus 1 cycle (the DONE handshake cycle) with `out_ready` held high.
- `x` need not be held after the accept edge.
- `in_valid` is ignored outside IDLE.

## Structure
- Shared `fpu_pkg`:
  - binary32 field widths and bias (127).
  - `FP_QNAN` = 32'h7FC00000, `FP_PINF` = 32'h7F800000.
  - state enum `fsqrt_state_t` {IDLE, CALC, DONE}.
- One sub-module, `fp_classify`: combinational; outputs is_zero, is_denorm, is_inf, is_nan, sign. It will be reused by other FPU ops.
- The recurrence step is inline in `fsqrt_iter`.

## Test plan
- x=32'h40800000 (4.0) -> y=32'h40000000; `out_valid` first high 26 cycles after accept. x=32'h41100000 (9.0) -> y=32'h40400000.
- x=32'h40000000 (2.0) -> y=32'h3FB504F3 (rounded); x=32'h3F800000 -> y=32'h3F800000.
- Specials, each producing `out_valid` 1 cycle after accept:
  - 32'hBF800000 -> 32'h7FC00000.
  - 32'h80000000 -> 32'h80000000.
  - 32'h7F800000 -> 32'h7F800000.
  - 32'h7FC00001 -> 32'h7FC00000.
  - 32'h00000001 -> 32'h00000000.
- Backpressure: hold `out_ready` low for 5 cycles after `out_valid`. `y` and `out_valid` stay stable, `in_ready` stays 0, and a pending `in_valid` is not accepted. The result completes on the first `out_ready` high.
- Pull `rstn` low at CALC step 10. Outputs go to 0 immediately. After release: `in_ready` = 1, no stale `out_valid`, and the next op (4.0) returns the correct result.
- Random normal operands vs. a reference model (bit-exact round-to-nearest).
